sha3_padding_unit: RTL
======================

// Module: sha3_padding_unit
// PURPOSE
// - Upstream absorb-side stage of the SHA-3 core. Collects 64-bit message words into one rate block of
//   R_BLOCK_SIZE bits, applies pad10*1 with the domain byte, and hands each block to the permutation module.
// - Drives VALID_MESSAGE_FROM_PADDING / LAST_MESSAGE_FROM_PADDING and holds OUT stable while waiting.
// - Paces hand-off with PERMUTATION_PROCESSING; a second block is never issued into a running permutation.
// PARAMETERS
// - R_BLOCK_SIZE  1152   rate in bits; multiple of 64 (1152/1088/832/576); W = R_BLOCK_SIZE/64 words per block
// - DOMAIN_PAD    8'h06  first pad byte (8'h06 SHA3, 8'h1F SHAKE)
// PORTS
// - CLK                         in   1    rising-edge clock
// - A_RST_N                     in   1    asynchronous reset, active low
// - CE                          in   1    clock enable; all state updates gated by it
// - DATA_IN                     in   64   message word; byte j = DATA_IN[8j:8j+7], j=0 first in stream
// - DATA_VALID                  in   1    DATA_IN valid this cycle
// - LAST_WORD                   in   1    word is last of message (qualified by DATA_VALID)
// - LAST_NUM_BYTES              in   4    valid bytes in last word, 0..8; values >8 treated as 8
// - DATA_READY                  out  1    word accepted when DATA_VALID & DATA_READY & CE
// - PERMUTATION_PROCESSING      in   1    permutation busy (high = rounds running)
// - OUT                         out  R    block; byte k = OUT[8k:8k+7], word s = bytes 8s..8s+7
// - VALID_MESSAGE_FROM_PADDING  out  1    one-cycle block hand-off pulse
// - LAST_MESSAGE_FROM_PADDING   out  1    qualifies the pulse: final block of message
// BEHAVIOUR
// - Reset: state=COLLECT, slot cnt=0, OUT=0, extra=0, last=0, busy_seen=1. Outputs: DATA_READY=1, pulse=0, LAST=0.
// - DATA_READY = (state==COLLECT). Words offered while DATA_READY=0 are ignored; the source holds them.
// - COLLECT, accepted non-last word: OUT word[cnt]<=DATA_IN.
//   - cnt==W-1: ->EMIT, last=0. Otherwise cnt++.
// - COLLECT, accepted last word, n=LAST_NUM_BYTES:
//   - Bytes <n copied, bytes >=n zeroed. Byte 8*cnt+n |= DOMAIN_PAD; byte R/8-1 |= 8'h80.
//   - Pad and end byte coincide: that byte = DOMAIN_PAD|8'h80 (8'h86 for SHA3).
//   - n==8 and cnt==W-1: no room for pad, so pad is deferred. ->EMIT, last=0, extra=1.
//   - Otherwise ->EMIT, last=1. n==0 at cnt==0 is the empty message.
// - EMIT: pulse = CE & busy_seen & !PERMUTATION_PROCESSING. Combinational; OUT stays registered and stable.
//   - LAST = pulse & last.
//   - On pulse: busy_seen<=0.
//   - On pulse with extra=1: OUT<=pad-only block (byte0=DOMAIN_PAD, byte R/8-1=8'h80, rest 0), last<=1, extra<=0, stay EMIT.
//   - On pulse otherwise: OUT<=0, cnt<=0, last<=0, ->COLLECT.
// - busy_seen<=1 on any CE cycle with PERMUTATION_PROCESSING=1. Blocks pulses on the cycles after a hand-off
//   until the permutation has visibly gone busy.
// - Latency: last accepted word to earliest pulse = 1 cycle.
// - CE=0: all registers frozen, pulse=0, DATA_READY still reflects state.
// - Reset mid-operation: partial block discarded, return to reset values immediately (async).
// STRUCTURE
// - sha3_pkg: STATE_SIZE=1600, Z_WIDTH=64, END_PAD=8'h80, typedef enum logic {COLLECT, EMIT} pad_state_t.
// - Sub-module sha3_pad_word (combinational): word, n, pad byte -> masked word plus pad byte.
//   The end byte is OR'd at block level.
// - Top: FSM, cnt of $clog2(W) bits, flags, R-bit block register with per-word write enable.
// TESTING
// - Empty message (LAST_WORD, n=0, R=1152) -> one pulse with LAST=1.
//   OUT byte0=06, byte143=80, all other bytes 00.
// - "abc" (DATA_IN=6162630000000000, n=3) -> bytes 0..2=61 62 63, byte3=06, byte143=80, single LAST pulse.
//   Core digest = e642824c3f8cf24ad09234ee7d3c766fc9a3a5168d0c94ad73b46fdf.
// - 144-byte message (18 words, last n=8 at slot 17) -> pulse 1: LAST=0, data block.
//   Pulse 2 only after PROCESSING high->low: LAST=1, pad-only block 06..80.
// - 143-byte message (last at slot 17, n=7) -> byte143=86, exactly one pulse, LAST=1.
// - PROCESSING held 1 for 30 cycles in EMIT -> no pulse, DATA_READY=0, OUT unchanged.
//   Pulse on first cycle PROCESSING=0. Two back-to-back blocks with PROCESSING stuck 0: second pulse never issues.
// - A_RST_N low after 5 words, then new 1-word message n=1 (8'hAA) -> byte0=AA, byte1=06, byte143=80.
//   CE=0 for 4 cycles mid-collect -> no state change.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 absorb-side padding logic.
package sha3_pkg;

  localparam int         STATE_SIZE = 1600;
  localparam int         Z_WIDTH    = 64;
  localparam logic [7:0] END_PAD    = 8'h80;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } pad_state_t;

  // Number of valid bytes in a final word; anything above 8 means a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Masks the final message word to its valid bytes and drops the domain pad
// byte into the first free byte position. Byte 0 is the most significant byte.
// A full word (n=8) gets no pad byte here; the block level places it.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [Z_WIDTH-1:0] word_in,
  input  logic [3:0]         num_bytes,
  input  logic [7:0]         pad_byte,
  output logic [Z_WIDTH-1:0] word_out
);

  logic [3:0] n_eff;

  // Keep bytes below n, put the pad byte at byte n, zero the rest.
  always_comb begin
    n_eff    = clamp_bytes(num_bytes);
    word_out = '0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < n_eff) begin
        word_out[Z_WIDTH-1-8*j -: 8] = word_in[Z_WIDTH-1-8*j -: 8];
      end else if (4'(j) == n_eff) begin
        word_out[Z_WIDTH-1-8*j -: 8] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/sha3_padding_unit.sv
// Collects 64-bit message words into one rate block, applies pad10*1 with the
// domain byte and hands each block to the permutation with a one-cycle pulse.
//
// Handshakes:
//   input side : a word transfers on a CE cycle where DATA_VALID and
//                DATA_READY are both high; the source holds the word otherwise.
//   output side: VALID_MESSAGE_FROM_PADDING is a single-cycle pulse; OUT is
//                registered and stays stable while the block waits. A block is
//                only released once the permutation has been seen busy since
//                the previous hand-off and is currently idle.
module sha3_padding_unit
  import sha3_pkg::*;
#(
  parameter int         R_BLOCK_SIZE = 1152,
  parameter logic [7:0] DOMAIN_PAD   = 8'h06
) (
  input  logic                    CLK,
  input  logic                    A_RST_N,
  input  logic                    CE,
  input  logic [Z_WIDTH-1:0]      DATA_IN,
  input  logic                    DATA_VALID,
  input  logic                    LAST_WORD,
  input  logic [3:0]              LAST_NUM_BYTES,
  output logic                    DATA_READY,
  input  logic                    PERMUTATION_PROCESSING,
  output logic [R_BLOCK_SIZE-1:0] OUT,
  output logic                    VALID_MESSAGE_FROM_PADDING,
  output logic                    LAST_MESSAGE_FROM_PADDING,
  output pad_state_t              dbg_state
);

  localparam int W  = R_BLOCK_SIZE / Z_WIDTH;
  localparam int CW = $clog2(W);

  pad_state_t              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [R_BLOCK_SIZE-1:0] out_q, out_d;
  logic                    last_q, last_d;
  logic                    extra_q, extra_d;
  logic                    busy_seen_q, busy_seen_d;

  logic                    accept;
  logic                    pulse;
  logic                    cnt_full;
  logic [3:0]              n_eff;
  logic [Z_WIDTH-1:0]      pad_word;
  logic [Z_WIDTH-1:0]      cur_word;
  logic                    wr_next;
  logic                    set_end;

  sha3_pad_word u_pad_word (
    .word_in   (DATA_IN),
    .num_bytes (LAST_NUM_BYTES),
    .pad_byte  (DOMAIN_PAD),
    .word_out  (pad_word)
  );

  assign accept    = CE && DATA_VALID && (state_q == COLLECT);
  assign pulse     = CE && (state_q == EMIT) && busy_seen_q && !PERMUTATION_PROCESSING;
  assign cnt_full  = (cnt_q == CW'(W - 1));
  assign n_eff     = clamp_bytes(LAST_NUM_BYTES);
  assign cur_word  = LAST_WORD ? pad_word : DATA_IN;

  assign DATA_READY                 = (state_q == COLLECT);
  assign VALID_MESSAGE_FROM_PADDING = pulse;
  assign LAST_MESSAGE_FROM_PADDING  = pulse && last_q;
  assign OUT                        = out_q;
  assign dbg_state                  = state_q;

  // Next-state logic: word collection, padding, block release and busy tracking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    last_d      = last_q;
    extra_d     = extra_q;
    busy_seen_d = busy_seen_q;
    wr_next     = 1'b0;
    set_end     = 1'b0;

    if (accept) begin
      // Per-word write enable: only slot cnt takes the incoming word.
      for (int s = 0; s < W; s++) begin
        if (CW'(s) == cnt_q) begin
          out_d[R_BLOCK_SIZE-1-Z_WIDTH*s -: Z_WIDTH] = cur_word;
        end
      end

      if (!LAST_WORD) begin
        if (cnt_full) begin
          state_d = EMIT;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        state_d = EMIT;
        if ((n_eff == 4'd8) && cnt_full) begin
          // Block is full of message bytes; padding goes into an extra block.
          last_d  = 1'b0;
          extra_d = 1'b1;
        end else begin
          last_d  = 1'b1;
          set_end = 1'b1;
          // A full final word pushes the pad byte to the start of the next slot.
          wr_next = (n_eff == 4'd8);
        end
      end

      for (int s = 1; s < W; s++) begin
        if (wr_next && (CW'(s - 1) == cnt_q)) begin
          out_d[R_BLOCK_SIZE-1-Z_WIDTH*s -: Z_WIDTH] = {DOMAIN_PAD, {(Z_WIDTH-8){1'b0}}};
        end
      end

      if (set_end) begin
        out_d[7:0] = out_d[7:0] | END_PAD;
      end
    end

    if (pulse) begin
      busy_seen_d = 1'b0;
      if (extra_q) begin
        out_d                       = '0;
        out_d[R_BLOCK_SIZE-1 -: 8]  = DOMAIN_PAD;
        out_d[7:0]                  = END_PAD;
        last_d                      = 1'b1;
        extra_d                     = 1'b0;
      end else begin
        out_d   = '0;
        cnt_d   = '0;
        last_d  = 1'b0;
        state_d = COLLECT;
      end
    end

    if (CE && PERMUTATION_PROCESSING) begin
      busy_seen_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_q       <= '0;
      last_q      <= 1'b0;
      extra_q     <= 1'b0;
      busy_seen_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      last_q      <= last_d;
      extra_q     <= extra_d;
      busy_seen_q <= busy_seen_d;
    end
  end

endmodule
